// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared types and helpers for the serial subtractor.
// The optional signed-overflow output is built in only when SERIAL_SUB_OVF_EN is defined.
package serial_sub_pkg;

    // Controller state.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Digit counter width. A single-digit operation still needs a one-bit counter.
    function automatic int cnt_width(input int n);
        if (n <= 1) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

    // One-bit full subtractor. Returns {borrow_out, difference}.
    function automatic logic [1:0] full_sub_bit(input logic x, input logic y, input logic br);
        logic d_v;
        logic br_v;
        d_v  = x ^ y ^ br;
        br_v = (~x & y) | (~(x ^ y) & br);
        return {br_v, d_v};
    endfunction

endpackage

// File: rtl/serial_sub_full_sub_slice.sv
// full_sub_slice: combinational DIGIT-bit full subtractor.
// The borrow ripples from bit 0 upwards through one-bit subtractor cells.
module full_sub_slice
    import serial_sub_pkg::*;
#(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             br_in,
    output logic [DIGIT-1:0] d,
    output logic             br_out
);

    logic [DIGIT:0] br_chain_s;
    logic [1:0]     cell_s;

    // Ripple the borrow through the cells, low bit first.
    always_comb begin
        br_chain_s    = {(DIGIT + 1){1'b0}};
        d             = {DIGIT{1'b0}};
        cell_s        = 2'b00;
        br_chain_s[0] = br_in;
        for (int i = 0; i < DIGIT; i++) begin
            cell_s            = full_sub_bit(x[i], y[i], br_chain_s[i]);
            d[i]              = cell_s[0];
            br_chain_s[i + 1] = cell_s[1];
        end
        br_out = br_chain_s[DIGIT];
    end

endmodule

// File: rtl/serial_sub.sv
// serial_sub: multi-cycle subtractor computing diff = a - b - bin, DIGIT bits per clock.
// A start/busy/done handshake frames each operation; results appear only on completion.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output ovf.
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = cnt_width(N);
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

    // Refuse to build when the digit size does not tile the operand.
    generate
        if ((DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_digit
            $error("serial_sub: DIGIT must be >= 1 and divide WIDTH exactly");
        end
    endgenerate

    state_t            state_r;
    logic [CW-1:0]     cnt_r;
    // Minuend shifts out from the bottom while result digits fill in from the top.
    logic [WIDTH-1:0]  ar_sh_r;
    logic [WIDTH-1:0]  b_sh_r;
    logic              br_r;
    logic              busy_r;
    logic              done_r;
    logic [WIDTH-1:0]  diff_r;
    logic              bout_r;

    logic [DIGIT-1:0]  d_s;
    logic              br_out_s;
    logic [WIDTH-1:0]  ar_next_s;
    logic [WIDTH-1:0]  b_next_s;

    full_sub_slice #(
        .DIGIT (DIGIT)
    ) u_slice (
        .x      (ar_sh_r[DIGIT-1:0]),
        .y      (b_sh_r[DIGIT-1:0]),
        .br_in  (br_r),
        .d      (d_s),
        .br_out (br_out_s)
    );

    // Next shift-register contents; a single-digit build has nothing left to shift.
    generate
        if (WIDTH == DIGIT) begin : g_one_digit
            assign ar_next_s = d_s;
            assign b_next_s  = {WIDTH{1'b0}};
        end else begin : g_multi_digit
            assign ar_next_s = {d_s, ar_sh_r[WIDTH-1:DIGIT]};
            assign b_next_s  = {{DIGIT{1'b0}}, b_sh_r[WIDTH-1:DIGIT]};
        end
    endgenerate

`ifdef SERIAL_SUB_OVF_EN
    logic a_msb_r;
    logic b_msb_r;
    logic ovf_r;
    logic ovf_next_s;

    // Signed overflow: operand signs differ and the result sign differs from the minuend.
    always_comb begin
        ovf_next_s = (a_msb_r ^ b_msb_r) & (ar_next_s[WIDTH-1] ^ a_msb_r);
    end

    // Keep operand sign bits, which leave the shift registers during the run.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_msb_r <= 1'b0;
            b_msb_r <= 1'b0;
            ovf_r   <= 1'b0;
        end else if ((state_r == IDLE) && start) begin
            a_msb_r <= a[WIDTH-1];
            b_msb_r <= b[WIDTH-1];
        end else if ((state_r == RUN) && (cnt_r == LAST_CNT)) begin
            ovf_r   <= ovf_next_s;
        end else begin
            ovf_r   <= ovf_r;
        end
    end

    assign ovf = ovf_r;
`endif

    // Controller: accept an operation when idle, process one digit per clock, publish at the end.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= {CW{1'b0}};
            ar_sh_r <= {WIDTH{1'b0}};
            b_sh_r  <= {WIDTH{1'b0}};
            br_r    <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            diff_r  <= {WIDTH{1'b0}};
            bout_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        ar_sh_r <= a;
                        b_sh_r  <= b;
                        br_r    <= bin;
                        cnt_r   <= {CW{1'b0}};
                        busy_r  <= 1'b1;
                        state_r <= RUN;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    ar_sh_r <= ar_next_s;
                    b_sh_r  <= b_next_s;
                    br_r    <= br_out_s;
                    cnt_r   <= cnt_r + {{(CW - 1){1'b0}}, 1'b1};
                    if (cnt_r == LAST_CNT) begin
                        diff_r  <= ar_next_s;
                        bout_r  <= br_out_s;
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        busy_r  <= 1'b1;
                        state_r <= RUN;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign diff = diff_r;
    assign bout = bout_r;

endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: directed bench for serial_sub (WIDTH=8 with DIGIT=1 and DIGIT=4 instances).
// Overflow checks are compiled in when SERIAL_SUB_OVF_EN is defined.
module tb_serial_sub;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       bin = 1'b0;
    logic       busy, done, bout;
    logic [7:0] diff;

    logic       start4 = 1'b0;
    logic [7:0] a4 = 8'h00;
    logic [7:0] b4 = 8'h00;
    logic       bin4 = 1'b0;
    logic       busy4, done4, bout4;
    logic [7:0] diff4;
`ifdef SERIAL_SUB_OVF_EN
    logic       ovf, ovf4;
`endif

    int vectors = 0;
    int miscompares = 0;

    serial_sub #(.WIDTH(8), .DIGIT(1)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
        .busy(busy), .done(done), .diff(diff), .bout(bout)
`ifdef SERIAL_SUB_OVF_EN
        , .ovf(ovf)
`endif
    );

    serial_sub #(.WIDTH(8), .DIGIT(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .bin(bin4),
        .busy(busy4), .done(done4), .diff(diff4), .bout(bout4)
`ifdef SERIAL_SUB_OVF_EN
        , .ovf(ovf4)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue an operation on the DIGIT=1 instance; returns just after the accepting edge.
    task automatic start_op(input logic [7:0] av, input logic [7:0] bv, input logic bv_in);
        a = av;
        b = bv;
        bin = bv_in;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    // Wait n edges; busy must hold until the last one, which must deliver done and the result.
    task automatic wait_done(input int n, input logic [7:0] ed, input logic eb, input string tag);
        for (int i = 1; i < n; i++) begin
            tick();
            check({tag, "_busy"}, {30'd0, busy, done}, 32'd2);
        end
        tick();
        check({tag, "_done"}, {30'd0, busy, done}, 32'd1);
        check({tag, "_diff"}, {24'd0, diff}, {24'd0, ed});
        check({tag, "_bout"}, {31'd0, bout}, {31'd0, eb});
    endtask

    initial begin
        logic [7:0] ra, rb;
        logic [8:0] ref_v;

        tick();
        tick();
        check("rst_outs", {20'd0, busy, done, bout, diff}, 32'd0);
        check("rst_outs4", {20'd0, busy4, done4, bout4, diff4}, 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        check("rst_ovf", {31'd0, ovf}, 32'd0);
`endif
        rst = 1'b0;
        tick();
        check("idle_no_busy", {30'd0, busy, done}, 32'd0);

        // Basic operations.
        start_op(8'h05, 8'h03, 1'b0);
        wait_done(8, 8'h02, 1'b0, "sub_5_3");
        tick();
        check("done_one_cycle", {31'd0, done}, 32'd0);
        check("diff_holds", {24'd0, diff}, 32'h02);
        start_op(8'h00, 8'h01, 1'b0);
        wait_done(8, 8'hFF, 1'b1, "sub_0_1");
        start_op(8'hFF, 8'hFF, 1'b1);
        wait_done(8, 8'hFF, 1'b1, "sub_ff_ff_b");

        // Random pairs with both borrow-in values against a wide-arithmetic reference.
        for (int i = 0; i < 256; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            for (int k = 0; k < 2; k++) begin
                ref_v = {1'b0, ra} - {1'b0, rb} - 9'(k);
                start_op(ra, rb, k[0]);
                wait_done(8, ref_v[7:0], ref_v[8], "rand");
            end
        end

        // Start during RUN is ignored; operand changes have no effect.
        start_op(8'h10, 8'h01, 1'b0);
        tick();
        tick();
        a = 8'hAA;
        b = 8'h55;
        bin = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(5, 8'h0F, 1'b0, "ignore_start");
        // Start in the done cycle is accepted; next done exactly 8 edges later.
        start_op(8'h20, 8'h03, 1'b0);
        wait_done(8, 8'h1D, 1'b0, "back_to_back");

        // Reset in cycle 4 of RUN aborts the operation.
        start_op(8'h5A, 8'h21, 1'b0);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_outs", {20'd0, busy, done, bout, diff}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("abort_no_done", {30'd0, busy, done}, 32'd0);
        end
        start_op(8'h5A, 8'h21, 1'b0);
        wait_done(8, 8'h39, 1'b0, "after_abort");

        // Four bits per clock.
        a4 = 8'h3C;
        b4 = 8'h4D;
        bin4 = 1'b0;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        check("d4_busy", {30'd0, busy4, done4}, 32'd2);
        tick();
        check("d4_busy2", {30'd0, busy4, done4}, 32'd2);
        tick();
        check("d4_done", {30'd0, busy4, done4}, 32'd1);
        check("d4_diff", {24'd0, diff4}, 32'hEF);
        check("d4_bout", {31'd0, bout4}, 32'd1);

`ifdef SERIAL_SUB_OVF_EN
        start_op(8'h80, 8'h01, 1'b0);
        wait_done(8, 8'h7F, 1'b0, "ovf_80_01");
        check("ovf_set", {31'd0, ovf}, 32'd1);
        start_op(8'h7F, 8'h01, 1'b0);
        wait_done(8, 8'h7E, 1'b0, "ovf_7f_01");
        check("ovf_clr", {31'd0, ovf}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
